// File: rtl/prm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prm_pkg : shared constants and scan-state encoding for PRM edge checkers   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package prm_pkg;

    localparam int c_num_edge = 512;
    localparam int c_code_w   = 15;
    localparam int c_chk_lat  = 1;
    localparam int c_cnt_w    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/prm_tok_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prm_tok_pipe : DEPTH-deep valid-token shift register with all-empty flag   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module prm_tok_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_tok,
    output logic o_tok,
    output logic o_empty
);

    logic [DEPTH-1:0] r_tok;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tok <= '0;
                end else if (i_clr) begin
                    r_tok <= '0;
                end else begin
                    r_tok <= i_tok;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tok <= '0;
                end else if (i_clr) begin
                    r_tok <= '0;
                end else begin
                    r_tok <= {r_tok[DEPTH-2:0], i_tok};
                end
            end
        end
    endgenerate

    assign o_tok   = r_tok[DEPTH-1];
    assign o_empty = ~|r_tok;

endmodule
`default_nettype wire

// File: rtl/prm_edge_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prm_edge_scan_ctrl : streams voxel codes through the PRM checker bank and  |
// |                      accumulates a sticky per-edge blocked bitmap          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module prm_edge_scan_ctrl
    import prm_pkg::*;
#(
    parameter int NUM_EDGE = c_num_edge,
    parameter int CODE_W   = c_code_w,
    parameter int CHK_LAT  = c_chk_lat,
    parameter int CNT_W    = c_cnt_w
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                abort,
    input  logic                vox_valid,
    input  logic [CODE_W-1:0]   vox_code,
    input  logic                vox_last,
    output logic                vox_ready,
    output logic [CODE_W-1:0]   chk_code,
    input  logic [NUM_EDGE-1:0] chk_mask,
    output logic [NUM_EDGE-1:0] blocked,
    output logic [CNT_W-1:0]    vox_count,
    output logic                busy,
    output logic                done
);

    scan_state_t         r_state;
    logic                r_vox_ready;
    logic                r_busy;
    logic                r_done;
    logic [CODE_W-1:0]   r_chk_code;
    logic [NUM_EDGE-1:0] r_blocked;
    logic [CNT_W-1:0]    r_vox_count;

    logic w_hs;
    logic w_scan_start;
    logic w_tok_out;
    logic w_tok_empty;

    assign w_hs         = vox_valid & r_vox_ready & ~abort;
    assign w_scan_start = start & ~abort & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    // Token k leaves the pipe exactly when the checker output for code k is valid.
    prm_tok_pipe #(
        .DEPTH (CHK_LAT)
    ) u_tok_pipe (
        .clk     (CLK),
        .rst     (RST),
        .i_clr   (abort | w_scan_start),
        .i_tok   (w_hs),
        .o_tok   (w_tok_out),
        .o_empty (w_tok_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_vox_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_chk_code  <= '0;
            r_blocked   <= '0;
            r_vox_count <= '0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_vox_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_blocked   <= '0;
            r_vox_count <= '0;
        end else begin
            if (w_tok_out) begin
                r_blocked <= r_blocked | chk_mask;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_SCAN;
                        r_vox_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_blocked   <= '0;
                        r_vox_count <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_hs) begin
                        r_chk_code <= vox_code;
                        if (r_vox_count != {CNT_W{1'b1}}) begin
                            r_vox_count <= r_vox_count + CNT_W'(1);
                        end
                        if (vox_last) begin
                            r_state     <= ST_DRAIN;
                            r_vox_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Empty pipe means the final capture landed on the previous edge.
                    if (w_tok_empty) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vox_ready = r_vox_ready;
    assign chk_code  = r_chk_code;
    assign blocked   = r_blocked;
    assign vox_count = r_vox_count;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
